// File: rtl/ballot_pkg.sv
// Shared definitions for the ballot controller: FSM state encoding, default
// poll timeout and the 2-of-3 majority helper.
// Latency: n/a (types and functions only). Backpressure: n/a.
package ballot_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POLL1  = 3'd1,
        POLL2  = 3'd2,
        POLL3  = 3'd3,
        DECIDE = 3'd4
    } state_t;

    // Cycles spent polling one voter before it is declared missing.
    localparam int TIMEOUT_DEFAULT = 16;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (b & c) | (a & c);
    endfunction

endpackage

// File: rtl/poll_timer.sv
// Per-poll cycle counter; expired flags the last allowed cycle of a poll.
// Latency: expired is combinational from the registered count.
// Backpressure: none; counts whenever enabled, clear has priority.
//
// Ports:
//   clk, rst  - clock and asynchronous active-high reset
//   clr       - zero the count on the next edge (used on every poll entry)
//   en        - increment the count on the next edge
//   expired   - count has reached TIMEOUT-1
module poll_timer
    import ballot_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CW      = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/ballot_controller.sv
// Polls three voters in turn, latches their votes and registers a majority,
// unanimity flag and missing-voter mask with a one-cycle done pulse.
// Latency: 5 edges from start to valid outputs minimum, 3*TIMEOUT+2 maximum.
// Backpressure: start is ignored while busy; each poll waits for vld up to TIMEOUT cycles.
//
// Ports:
//   clk, rst          - clock and asynchronous active-high reset
//   start             - begin a ballot (only honoured in IDLE)
//   v1..v3, vld1..3   - vote value and valid from each voter
//   req1..3           - poll request, high while that voter is being polled
//   busy              - ballot in progress
//   done              - one-cycle pulse when result/unanimous/missing update
//   result            - majority of latched votes (missing voters count as 0)
//   unanimous         - all three voters answered with the same value
//   missing           - bit n-1 set if voter n timed out
module ballot_controller
    import ballot_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CW      = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       v1,
    input  logic       v2,
    input  logic       v3,
    input  logic       vld1,
    input  logic       vld2,
    input  logic       vld3,
    output logic       req1,
    output logic       req2,
    output logic       req3,
    output logic       busy,
    output logic       done,
    output logic       result,
    output logic       unanimous,
    output logic [2:0] missing
);

    state_t     state, state_nxt;
    logic [2:0] poll_mask;   // one-hot: which voter is being polled
    logic       sel_vld;
    logic       sel_v;
    logic       expired;
    logic       timer_clr;
    logic [2:0] votes;
    logic [2:0] miss_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        poll_mask = 3'b000;
        sel_vld   = 1'b0;
        sel_v     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = POLL1;
            end
            POLL1: begin
                poll_mask = 3'b001;
                sel_vld   = vld1;
                sel_v     = v1;
                if (vld1 || expired) state_nxt = POLL2;
            end
            POLL2: begin
                poll_mask = 3'b010;
                sel_vld   = vld2;
                sel_v     = v2;
                if (vld2 || expired) state_nxt = POLL3;
            end
            POLL3: begin
                poll_mask = 3'b100;
                sel_vld   = vld3;
                sel_v     = v3;
                if (vld3 || expired) state_nxt = DECIDE;
            end
            DECIDE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign req1 = poll_mask[0];
    assign req2 = poll_mask[1];
    assign req3 = poll_mask[2];
    assign busy = (state != IDLE);

    // Any state change restarts the timer, so each poll starts counting at zero.
    assign timer_clr = (state_nxt != state);

    poll_timer #(
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr),
        .en      (poll_mask != 3'b000),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            votes     <= 3'b000;
            miss_acc  <= 3'b000;
            result    <= 1'b0;
            unanimous <= 1'b0;
            missing   <= 3'b000;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && start) begin
                votes    <= 3'b000;
                miss_acc <= 3'b000;
            end
            // vld wins over expiry, so an answer in the last cycle still counts.
            for (int i = 0; i < 3; i++) begin
                if (poll_mask[i]) begin
                    if (sel_vld) begin
                        votes[i] <= sel_v;
                    end else if (expired) begin
                        votes[i]    <= 1'b0;
                        miss_acc[i] <= 1'b1;
                    end
                end
            end
            if (state == DECIDE) begin
                result    <= majority3(votes[0], votes[1], votes[2]);
                unanimous <= (miss_acc == 3'b000) && (votes == 3'b000 || votes == 3'b111);
                missing   <= miss_acc;
                done      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ballot_controller.sv
// Self-checking bench for ballot_controller: directed ballots plus random ballots
// with noise on non-polled voters and on start, checked against a counting model.
// Runs to completion on its own and prints a single summary line.
module tb_ballot_controller;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       v1, v2, v3;
    logic       vld1, vld2, vld3;
    logic       req1, req2, req3;
    logic       busy, done, result, unanimous;
    logic [2:0] missing;

    int npass = 0;
    int nfail = 0;
    int ntot  = 0;

    logic       exp_res;
    logic       exp_una;
    logic [2:0] exp_miss;

    ballot_controller #(.TIMEOUT(T), .CW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .v1        (v1),
        .v2        (v2),
        .v3        (v3),
        .vld1      (vld1),
        .vld2      (vld2),
        .vld3      (vld3),
        .req1      (req1),
        .req2      (req2),
        .req3      (req3),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .unanimous (unanimous),
        .missing   (missing)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic drive(input int n, input logic vl, input logic vv);
        case (n)
            1: begin vld1 = vl; v1 = vv; end
            2: begin vld2 = vl; v2 = vv; end
            default: begin vld3 = vl; v3 = vv; end
        endcase
    endtask

    // One full ballot. vote[n-1] is voter n's value; d[n-1] is how many cycles
    // into its poll voter n raises vld (>= T means it never answers).
    // mode 0: non-polled voters quiet; 1: random noise on them and on start;
    // 2: non-polled voters hold vld high with their own vote.
    // Entered and left at a negedge; ends in the done cycle with start low.
    task automatic run_ballot(input logic [2:0] vote, input int d1, input int d2,
                              input int d3, input int mode);
        int d[3];
        int len[3];
        int s;
        int ones;
        int p;
        int c;
        bit all_present;
        d[0] = d1; d[1] = d2; d[2] = d3;
        ones = 0;
        all_present = 1'b1;
        exp_miss = 3'b000;
        for (int n = 0; n < 3; n++) begin
            if (d[n] < T) begin
                len[n] = d[n] + 1;
                if (vote[n]) ones++;
            end else begin
                len[n] = T;
                exp_miss[n] = 1'b1;
                all_present = 1'b0;
            end
        end
        exp_res = (ones >= 2);
        exp_una = all_present && (vote == 3'b000 || vote == 3'b111);
        s = len[0] + len[1] + len[2];

        start = 1'b1;
        for (int i = 0; i <= s + 1; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i < len[0]) begin
                p = 1; c = i;
            end else if (i < len[0] + len[1]) begin
                p = 2; c = i - len[0];
            end else if (i < s) begin
                p = 3; c = i - len[0] - len[1];
            end else begin
                p = 0; c = 0;
            end
            start = (mode == 1 && p != 0) ? 1'($urandom) : 1'b0;
            for (int n = 1; n <= 3; n++) begin
                if (n == p)         drive(n, (c >= d[n-1]), vote[n-1]);
                else if (mode == 1) drive(n, 1'($urandom), 1'($urandom));
                else if (mode == 2) drive(n, 1'b1, vote[n-1]);
                else                drive(n, 1'b0, 1'b0);
            end
            check("req", {req3, req2, req1}, {p == 3, p == 2, p == 1});
            check("busy", busy, (i <= s));
            if (i <= s) begin
                check("done_early", done, 1'b0);
            end else begin
                check("done", done, 1'b1);
                check("result", result, exp_res);
                check("unanimous", unanimous, exp_una);
                check("missing", missing, exp_miss);
            end
        end
    endtask

    // One cycle after a ballot with no new start: done gone, outputs held.
    task automatic idle_check();
        @(posedge clk);
        @(negedge clk);
        check("done_pulse_once", done, 1'b0);
        check("busy_idle", busy, 1'b0);
        check("req_idle", {req3, req2, req1}, 3'b000);
        check("result_hold", result, exp_res);
        check("unanimous_hold", unanimous, exp_una);
        check("missing_hold", missing, exp_miss);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        for (int n = 1; n <= 3; n++) drive(n, 1'b0, 1'b0);
        @(negedge clk);
        check("rst_req", {req3, req2, req1}, 3'b000);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_result", result, 1'b0);
        check("rst_unanimous", unanimous, 1'b0);
        check("rst_missing", missing, 3'b000);
        rst = 1'b0;
        @(negedge clk);

        // Minimum-latency ballot, vlds held high, votes 1,0,1.
        run_ballot(3'b101, 0, 0, 0, 2);
        idle_check();
        // Unanimous 1s, each voter answers after 3 cycles.
        run_ballot(3'b111, 3, 3, 3, 0);
        idle_check();
        // Voter 2 silent for the whole timeout, noise elsewhere.
        run_ballot(3'b001, 0, 99, 0, 1);
        idle_check();
        // Voter 2 answers in the last timeout cycle; next ballot back-to-back.
        run_ballot(3'b011, 0, T - 1, 0, 0);
        run_ballot(3'b000, 1, 0, 2, 1);
        idle_check();

        // Async reset in the middle of POLL2, after a ballot left result=1.
        run_ballot(3'b111, 0, 0, 0, 0);
        idle_check();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        drive(1, 1'b1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(1, 1'b0, 1'b0);
        check("poll2_before_rst", {req3, req2, req1}, 3'b010);
        #2 rst = 1'b1;
        #1;
        check("arst_req", {req3, req2, req1}, 3'b000);
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_result", result, 1'b0);
        check("arst_unanimous", unanimous, 1'b0);
        check("arst_missing", missing, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_ballot(3'b011, 2, 5, 99, 1);
        idle_check();

        // Random ballots, some back-to-back.
        for (int k = 0; k < 30; k++) begin
            run_ballot(3'($urandom), $urandom_range(0, 21), $urandom_range(0, 21),
                       $urandom_range(0, 21), 1);
            if ($urandom_range(0, 2) != 0) idle_check();
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
